sm_mult_seq: RTL and testbench

//   Sequential shift-add sign-magnitude multiplier with valid/ready handshakes on input and output.

---
 rtl/sm_mult_seq.sv | 125 ++++++++++++
 tb/tb_sm_mult_seq.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/sm_mult_seq.sv
// sm_mult_seq: sequential shift-add sign-magnitude multiplier.
// Operands and result use a valid/ready handshake, and one magnitude bit is processed per clock.
// Optional macro SM_MULT_NEG_ZERO_FIX_EN: when defined, a zero product always gets sign 0 (+0).
module sm_mult_seq #(
    parameter int unsigned W = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [W-1:0]         in1,
    input  logic [W-1:0]         in2,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [2*(W-1):0]     out,
    output logic                 busy
);

    localparam int unsigned M  = W - 1;
    localparam int unsigned PW = 2 * M;
    localparam int unsigned OW = PW + 1;
    localparam int unsigned CW = (M > 1) ? $clog2(M) : 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t          r_state;
    state_t          w_state_next;
    logic            w_accept;
    logic            w_last;
    logic            w_sign_in;
    logic [M-1:0]    r_mag_a;
    logic [M-1:0]    r_mag_b;
    logic            r_sign;
    logic [PW-1:0]   r_acc;
    logic [CW-1:0]   r_cnt;
    logic [OW-1:0]   r_out;
    logic [PW-1:0]   w_addend;
    logic [PW-1:0]   w_acc_sum;

    // Product sign; optionally suppress -0 when either magnitude is zero
`ifdef SM_MULT_NEG_ZERO_FIX_EN
    assign w_sign_in = (in1[W-1] ^ in2[W-1]) &
                       (in1[M-1:0] != '0) & (in2[M-1:0] != '0);
`else
    assign w_sign_in = in1[W-1] ^ in2[W-1];
`endif

    // Partial product for the current multiplier bit, added to the running sum
    assign w_addend  = r_mag_b[0] ? (PW'(r_mag_a) << r_cnt) : '0;
    assign w_acc_sum = r_acc + w_addend;

    // Handshake flags are pure state decodes
    assign in_ready  = (r_state == S_IDLE);
    assign out_valid = (r_state == S_DONE);
    assign busy      = (r_state != S_IDLE);
    assign out       = r_out;

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic and datapath strobes
    always_comb begin
        w_state_next = r_state;
        w_accept     = 1'b0;
        w_last       = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (in_valid) begin
                    w_accept     = 1'b1;
                    w_state_next = S_CALC;
                end
            end
            S_CALC: begin
                if (r_cnt == CW'(M - 1)) begin
                    w_last       = 1'b1;
                    w_state_next = S_DONE;
                end
            end
            S_DONE: begin
                if (out_ready) begin
                    w_state_next = S_IDLE;
                end
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    // Operand latch, shift-add iteration and result capture
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_mag_a <= '0;
            r_mag_b <= '0;
            r_sign  <= 1'b0;
            r_acc   <= '0;
            r_cnt   <= '0;
            r_out   <= '0;
        end else if (w_accept) begin
            r_mag_a <= in1[M-1:0];
            r_mag_b <= in2[M-1:0];
            r_sign  <= w_sign_in;
            r_acc   <= '0;
            r_cnt   <= '0;
        end else if (r_state == S_CALC) begin
            r_acc   <= w_acc_sum;
            r_mag_b <= r_mag_b >> 1;
            r_cnt   <= r_cnt + CW'(1);
            if (w_last) begin
                r_out <= {r_sign, w_acc_sum};
            end
        end
    end

endmodule

// File: tb/tb_sm_mult_seq.sv
// Bench for sm_mult_seq: a cycle-level reference model compared against the W=8 DUT on every cycle,
// hand-computed literal products, and a W=4 instance exercised with literal cases.
module tb_sm_mult_seq;

    localparam int M8 = 7;
    localparam int M4 = 3;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid, out_ready;
    logic [7:0]  in1, in2;
    logic        in_ready, out_valid, busy;
    logic [14:0] out;

    logic        in_valid4, out_ready4;
    logic [3:0]  in1_4, in2_4;
    logic        in_ready4, out_valid4, busy4;
    logic [6:0]  out4;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    sm_mult_seq #(.W(8)) u_dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in1(in1), .in2(in2), .out_valid(out_valid), .out_ready(out_ready),
        .out(out), .busy(busy)
    );

    sm_mult_seq #(.W(4)) u_dut4 (
        .clk(clk), .rst(rst), .in_valid(in_valid4), .in_ready(in_ready4),
        .in1(in1_4), .in2(in2_4), .out_valid(out_valid4), .out_ready(out_ready4),
        .out(out4), .busy(busy4)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference product: sign-magnitude multiply in plain arithmetic
    function automatic logic [14:0] ref_mul8(input logic [7:0] a, input logic [7:0] b);
        int unsigned p;
        logic s;
        p = int'(a[6:0]) * int'(b[6:0]);
        s = a[7] ^ b[7];
`ifdef SM_MULT_NEG_ZERO_FIX_EN
        if (p == 0) s = 1'b0;
`endif
        return {s, 14'(p)};
    endfunction

    // Behavioural model: a transaction accepted while idle yields its product M8 cycles later,
    // which then stays visible until the consumer takes it.
    bit        m_pending = 1'b0;
    bit        m_valid   = 1'b0;
    int        m_left    = 0;
    bit [14:0] m_next    = '0;
    bit [14:0] m_out     = '0;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_pending = 1'b0;
            m_valid   = 1'b0;
            m_out     = '0;
        end else if (m_valid) begin
            if (out_ready) m_valid = 1'b0;
        end else if (m_pending) begin
            m_left--;
            if (m_left == 0) begin
                m_pending = 1'b0;
                m_valid   = 1'b1;
                m_out     = m_next;
            end
        end else if (in_valid) begin
            m_pending = 1'b1;
            m_left    = M8;
            m_next    = ref_mul8(in1, in2);
        end
    end

    bit cmp_en = 1'b0;

    // Cycle-by-cycle comparison of the W=8 DUT against the model
    always @(negedge clk) begin
        if (cmp_en) begin
            chk("out_valid", 32'(out_valid), 32'(m_valid));
            chk("in_ready",  32'(in_ready),  32'(!(m_pending || m_valid)));
            chk("busy",      32'(busy),      32'(m_pending || m_valid));
            chk("out",       32'(out),       32'(m_out));
        end
    end

    task automatic run_op(input logic [7:0] a, input logic [7:0] b, input bit rnd,
                          output logic [14:0] res, output int lat);
        int guard;
        @(negedge clk);
        in1 = a; in2 = b; in_valid = 1'b1;
        out_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        in1 = 8'($urandom); in2 = 8'($urandom);
        lat = 0;
        while (!out_valid && lat < 50) begin
            if (rnd) out_ready = 1'($urandom_range(0, 1));
            @(negedge clk);
            lat++;
        end
        if (lat >= 50) chk("timeout_valid", 32'(out_valid), 32'(1));
        res = out;
        guard = 0;
        while (out_valid && guard < 50) begin
            out_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            @(negedge clk);
            guard++;
        end
        if (guard >= 50) chk("timeout_drain", 32'(out_valid), 32'(0));
        out_ready = 1'b1;
    endtask

    task automatic run4(input logic [3:0] a, input logic [3:0] b, input logic [6:0] exp);
        int lat;
        @(negedge clk);
        in1_4 = a; in2_4 = b; in_valid4 = 1'b1; out_ready4 = 1'b1;
        @(negedge clk);
        in_valid4 = 1'b0;
        lat = 0;
        while (!out_valid4 && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        chk("w4_latency", 32'(lat), 32'(M4));
        chk("w4_out", 32'(out4), 32'(exp));
        @(negedge clk);
        chk("w4_pulse", 32'(out_valid4), 32'(0));
        chk("w4_in_ready", 32'(in_ready4), 32'(1));
        chk("w4_busy", 32'(busy4), 32'(0));
    endtask

    initial begin
        logic [14:0] res;
        int lat;
        int seen;
        logic [7:0] a, b;

        rst = 1'b1;
        in_valid = 1'b0; out_ready = 1'b1; in1 = '0; in2 = '0;
        in_valid4 = 1'b0; out_ready4 = 1'b1; in1_4 = '0; in2_4 = '0;
        cmp_en = 1'b1;
        @(negedge clk);
        chk("rst_in_ready", 32'(in_ready), 32'(1));
        chk("rst_out", 32'(out), 32'(0));
        chk("rst_out_valid", 32'(out_valid), 32'(0));
        @(negedge clk);
        #2 rst = 1'b0;

        // Directed products with hand-computed results
        run_op(8'h02, 8'h04, 1'b0, res, lat);
        chk("t1_out", 32'(res), 32'h0008);
        chk("t1_latency", 32'(lat), 32'(M8));
        run_op(8'h82, 8'h04, 1'b0, res, lat);
        chk("t2a_out", 32'(res), 32'h4008);
        run_op(8'h82, 8'h84, 1'b0, res, lat);
        chk("t2b_out", 32'(res), 32'h0008);
        run_op(8'h7F, 8'h7F, 1'b0, res, lat);
        chk("t3a_out", 32'(res), 32'h3F01);
        run_op(8'hFF, 8'h7F, 1'b0, res, lat);
        chk("t3b_out", 32'(res), 32'h7F01);
        run_op(8'h80, 8'h05, 1'b0, res, lat);
`ifdef SM_MULT_NEG_ZERO_FIX_EN
        chk("t5_out", 32'(res), 32'h0000);
`else
        chk("t5_out", 32'(res), 32'h4000);
`endif
        chk("t5_out_reset_after", 32'(out), 32'(res));

        // Backpressure: hold out_ready low in DONE and try to inject a new operand
        @(negedge clk);
        in1 = 8'h03; in2 = 8'h05; in_valid = 1'b1; out_ready = 1'b0;
        @(negedge clk);
        in_valid = 1'b0;
        seen = 0;
        while (!out_valid && seen < 20) begin @(negedge clk); seen++; end
        for (int i = 0; i < 5; i++) begin
            in_valid = (i == 2);
            in1 = 8'h11; in2 = 8'h22;
            @(negedge clk);
            chk("bp_out", 32'(out), 32'h000F);
            chk("bp_valid", 32'(out_valid), 32'(1));
            chk("bp_in_ready", 32'(in_ready), 32'(0));
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        chk("bp_drained", 32'(out_valid), 32'(0));
        chk("bp_in_ready_after", 32'(in_ready), 32'(1));
        chk("bp_out_kept", 32'(out), 32'h000F);

        // Reset in the middle of CALC aborts the operation
        @(negedge clk);
        in1 = 8'h55; in2 = 8'h33; in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (3) @(negedge clk);
        #2 rst = 1'b1;
        @(negedge clk);
        #2 rst = 1'b0;
        seen = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (out_valid) seen++;
        end
        chk("rst_abort_no_valid", 32'(seen), 32'(0));
        chk("rst_abort_in_ready", 32'(in_ready), 32'(1));
        run_op(8'h03, 8'h03, 1'b0, res, lat);
        chk("post_rst_out", 32'(res), 32'h0009);

        // Randomized operands with random consumer backpressure
        for (int i = 0; i < 40; i++) begin
            a = 8'($urandom);
            b = 8'($urandom);
            if (i == 0) a[6:0] = '0;
            if (i == 1) b[6:0] = 7'h7F;
            run_op(a, b, 1'b1, res, lat);
            chk("rand_out", 32'(res), 32'(ref_mul8(a, b)));
        end

        // Narrow instance
        run4(4'h2, 4'h4, 7'h08);
        run4(4'hA, 4'h4, 7'h48);
        run4(4'hA, 4'hC, 7'h08);
        run4(4'h7, 4'h7, 7'h31);
        run4(4'hF, 4'h7, 7'h71);

        cmp_en = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    // Global watchdog
    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
